// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: shift mode codes
// and the burst controller state encoding.
package shift_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step. Shared by the single-shift and burst paths.
// Mode 2'b11 falls through to logical behaviour.
module shift_step
  import shift_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic [Width-1:0] value,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             shiftIn,
  output logic [Width-1:0] nextValue,
  output logic             outBit
);

  logic fill;

  // Select the fill bit for the chosen direction/mode, then shift.
  always_comb begin
    fill      = shiftIn;
    nextValue = value;
    outBit    = 1'b0;
    if (!dir) begin
      outBit = value[0];
      case (mode)
        MODE_ROT:   fill = value[0];
        MODE_ARITH: fill = value[Width-1];
        default:    fill = shiftIn;
      endcase
      nextValue = {fill, value[Width-1:1]};
    end else begin
      outBit = value[Width-1];
      case (mode)
        MODE_ROT:   fill = value[Width-1];
        MODE_ARITH: fill = 1'b0;
        default:    fill = shiftIn;
      endcase
      nextValue = {value[Width-2:0], fill};
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, single steps, and an autonomous
// burst engine performing up to Width steps with a busy/done handshake.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int Width = 8,
  parameter int CntW  = $clog2(Width + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] loadValue,
  input  logic             shift,
  input  logic             burst,
  input  logic [CntW-1:0]  burstLen,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             shiftIn,
  output logic [Width-1:0] shiftReg,
  output logic             shiftOut,
  output logic             busy,
  output logic             done
);

  state_t            state;
  logic [CntW-1:0]   remaining;
  logic              latDir;
  logic [1:0]        latMode;
  logic [CntW-1:0]   lenClamped;
  logic              stepDir;
  logic [1:0]        stepMode;
  logic [Width-1:0]  stepValue;
  logic              stepOut;

  // Burst steps use the direction/mode captured at start; single steps use live inputs.
  always_comb begin
    stepDir    = (state == SHIFT) ? latDir  : dir;
    stepMode   = (state == SHIFT) ? latMode : mode;
    lenClamped = (burstLen > CntW'(Width)) ? CntW'(Width) : burstLen;
  end

  shift_step #(
    .Width (Width)
  ) u_step (
    .value     (shiftReg),
    .dir       (stepDir),
    .mode      (stepMode),
    .shiftIn   (shiftIn),
    .nextValue (stepValue),
    .outBit    (stepOut)
  );

  // Controller and datapath registers; load overrides everything but reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      latDir    <= 1'b0;
      latMode   <= MODE_LOGIC;
      shiftReg  <= '0;
      shiftOut  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shiftReg  <= loadValue;
        state     <= IDLE;
        remaining <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (burst) begin
              latDir    <= dir;
              latMode   <= mode;
              remaining <= lenClamped;
              if (lenClamped != '0) begin
                state <= SHIFT;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end else if (shift) begin
              shiftReg <= stepValue;
              shiftOut <= stepOut;
            end
          end
          SHIFT: begin
            shiftReg  <= stepValue;
            shiftOut  <= stepOut;
            remaining <= remaining - CntW'(1);
            if (remaining == CntW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (Width=8): behavioural model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  loadValue = '0;
  logic          shift = 1'b0;
  logic          burst = 1'b0;
  logic [CW-1:0] burstLen = '0;
  logic          dir = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          shiftIn = 1'b0;
  logic [W-1:0]  shiftReg;
  logic          shiftOut;
  logic          busy;
  logic          done;

  int nVec  = 0;
  int nFail = 0;

  shift_reg_univ #(.Width(W), .CntW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .loadValue (loadValue),
    .shift     (shift),
    .burst     (burst),
    .burstLen  (burstLen),
    .dir       (dir),
    .mode      (mode),
    .shiftIn   (shiftIn),
    .shiftReg  (shiftReg),
    .shiftOut  (shiftOut),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   mReg, mOut, mDone, mRem, mDir, mMode;

  // One step on an integer value using plain arithmetic.
  function automatic void mstep(input int r, input int d, input int md, input int fin,
                                output int nr, output int o);
    int fill;
    if (d == 0) begin
      o    = r % 2;
      fill = (md == 1) ? o : (md == 2) ? r / 128 : fin;
      nr   = r / 2 + fill * 128;
    end else begin
      o    = r / 128;
      fill = (md == 1) ? o : (md == 2) ? 0 : fin;
      nr   = (r * 2) % 256 + fill;
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    int nr, o, n;
    if (reset) begin
      mReg = 0; mOut = 0; mDone = 0; mRem = 0; mDir = 0; mMode = 0;
    end else begin
      mDone = 0;
      if (load) begin
        mReg = int'(loadValue);
        mRem = 0;
      end else if (mRem > 0) begin
        mstep(mReg, mDir, mMode, int'(shiftIn), nr, o);
        mReg = nr; mOut = o;
        mRem--;
        if (mRem == 0) mDone = 1;
      end else if (burst) begin
        n     = (int'(burstLen) > W) ? W : int'(burstLen);
        mDir  = int'(dir);
        mMode = int'(mode);
        mRem  = n;
        if (n == 0) mDone = 1;
      end else if (shift) begin
        mstep(mReg, int'(dir), int'(mode), int'(shiftIn), nr, o);
        mReg = nr; mOut = o;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clock) begin
    check("shiftReg", int'(shiftReg), mReg);
    check("shiftOut", int'(shiftOut), mOut);
    check("busy",     int'(busy),     (mRem > 0) ? 1 : 0);
    check("done",     int'(done),     mDone);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    load = 1'b0; shift = 1'b0; burst = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; loadValue = v;
    tick();
    load = 1'b0;
  endtask

  // Issue a burst and count the busy cycles until it ends (bounded).
  task automatic run_burst(input int len, input logic d, input logic [1:0] md,
                           input logic fin, input string tag, output int nBusy);
    burst = 1'b1; burstLen = CW'(len); dir = d; mode = md; shiftIn = fin;
    tick();
    burst = 1'b0;
    nBusy = 0;
    while (busy && nBusy < 20) begin
      nBusy++;
      tick();
    end
    if (nBusy >= 20) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int nb;
    int sawDone;

    // Reset state
    tick();
    tick();
    check("rst_reg",  int'(shiftReg), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    tick();

    // Reset asserted in the middle of a 5-step burst
    do_load(8'hAA);
    burst = 1'b1; burstLen = CW'(5); dir = 1'b0; mode = 2'b00;
    tick();
    burst = 1'b0;
    tick();
    check("mid_busy_before_rst", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_reg",  int'(shiftReg), 0);
    check("mid_rst_out",  int'(shiftOut), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    tick();
    reset = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) sawDone = 1;
    end
    check("mid_rst_no_done", sawDone, 0);

    // Single logical right shift, fill 1
    do_load(8'hB4);
    shift = 1'b1; dir = 1'b0; mode = 2'b00; shiftIn = 1'b1;
    tick();
    shift = 1'b0;
    check("shr_reg",  int'(shiftReg), 8'hDA);
    check("shr_out",  int'(shiftOut), 0);
    check("shr_done", int'(done), 0);
    check("shr_busy", int'(busy), 0);

    // Burst of 3 rotate-left
    do_load(8'h96);
    run_burst(3, 1'b1, 2'b01, 1'b0, "rotl", nb);
    check("rotl_busy_cycles", nb, 3);
    check("rotl_reg",  int'(shiftReg), 8'hB4);
    check("rotl_out",  int'(shiftOut), 0);
    check("rotl_done", int'(done), 1);
    tick();
    check("rotl_done_pulse", int'(done), 0);

    // Burst of 4 arithmetic-right with dir toggled mid-burst
    do_load(8'h90);
    burst = 1'b1; burstLen = CW'(4); dir = 1'b0; mode = 2'b10;
    tick();
    burst = 1'b0;
    dir = 1'b1; mode = 2'b00;
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      dir = ~dir;
      tick();
    end
    check("asr_busy_cycles", nb, 4);
    check("asr_reg",  int'(shiftReg), 8'hF9);
    check("asr_out",  int'(shiftOut), 0);
    check("asr_done", int'(done), 1);

    // Zero-length burst
    tick();
    do_load(8'h5A);
    burst = 1'b1; burstLen = '0; dir = 1'b0; mode = 2'b00;
    tick();
    burst = 1'b0;
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_reg",  int'(shiftReg), 8'h5A);
    tick();
    check("zero_done_pulse", int'(done), 0);

    // Saturating burst length
    do_load(8'hFF);
    run_burst(15, 1'b1, 2'b00, 1'b0, "sat", nb);
    check("sat_busy_cycles", nb, 8);
    check("sat_reg",  int'(shiftReg), 8'h00);
    check("sat_out",  int'(shiftOut), 1);
    check("sat_done", int'(done), 1);
    tick();

    // Load during the second busy cycle of a 6-step burst
    do_load(8'h81);
    burst = 1'b1; burstLen = CW'(6); dir = 1'b0; mode = 2'b01;
    tick();
    burst = 1'b0;
    tick();
    check("ldmid_busy", int'(busy), 1);
    load = 1'b1; loadValue = 8'h3C;
    tick();
    load = 1'b0;
    check("ldmid_reg",  int'(shiftReg), 8'h3C);
    check("ldmid_busy_after", int'(busy), 0);
    check("ldmid_done", int'(done), 0);
    shift = 1'b1; dir = 1'b0; mode = 2'b00; shiftIn = 1'b0;
    tick();
    shift = 1'b0;
    check("ldmid_shift_reg", int'(shiftReg), 8'h1E);
    check("ldmid_no_done", int'(done), 0);

    // Random traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 600; i++) begin
      load      = ($urandom_range(0, 15) == 0);
      loadValue = W'($urandom);
      burst     = ($urandom_range(0, 7) == 0);
      burstLen  = CW'($urandom_range(0, 15));
      shift     = ($urandom_range(0, 2) == 0);
      dir       = 1'($urandom);
      mode      = 2'($urandom);
      shiftIn   = 1'($urandom);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, the next generation of the 4-bit right-shift register in the serial-multiplier path. Adds configurable width, left/right direction, logical/rotate/arithmetic modes, a serial output bit, and a burst engine that performs N shifts autonomously with busy/done handshake. It is the operand/accumulator register for the upcoming multi-width serial multiplier.

## Interface
Parameters:
- Width, 8, register width in bits (≥2)
- CntW, $clog2(Width+1), width of burst length field

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  parallel load of loadValue; highest priority after reset
- loadValue  in  Width  parallel load data
- shift  in  1  single-step shift request (accepted only when idle)
- burst  in  1  start a multi-step shift of burstLen steps (accepted only when idle)
- burstLen  in  CntW  number of steps; values >Width saturate to Width
- dir  in  1  0 = right (toward LSB), 1 = left
- mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 treated as logical
- shiftIn  in  1  fill bit for logical mode, sampled at every step
- shiftReg  out  Width  register contents
- shiftOut  out  1  bit shifted out by the most recent step
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the last burst step

## Operation
- Step rules (Width=W): right logical {shiftIn, r[W-1:1]}, out r[0]; left logical {r[W-2:0], shiftIn}, out r[W-1]; rotate right/left feeds the out bit back in; arithmetic right {r[W-1], r[W-1:1]}; arithmetic left = logical left with fill 0.
- FSM states: IDLE, SHIFT.
- IDLE: priority load > burst > shift. burst latches dir, mode, and min(burstLen, W) into a remaining counter; goes to SHIFT if count ≥1, else stays IDLE and pulses done. shift performs one step with live dir/mode; no done pulse.
- SHIFT: each edge performs one step with latched dir/mode, live shiftIn, decrements counter; on the step where counter = 1 → IDLE, done = 1.
- load in any state: shiftReg ← loadValue, state → IDLE, counter cleared, no done, shiftOut unchanged.
- shift or burst while in SHIFT: ignored. burst and shift together in IDLE: burst wins.

## Timing
- Reset (async assert, sync release): shiftReg = 0, shiftOut = 0, busy = 0, done = 0, state IDLE, counter 0.
- Load: value visible the cycle after the sampling edge.
- Single shift: result and shiftOut visible the cycle after the sampling edge.
- Burst of N≥1: start edge E0; busy high cycles E0+1 .. E0+N; steps at edges E0+1 .. E0+N; final value and done visible cycle after E0+N (done high exactly one cycle, busy low).
- Burst of N=0: done high cycle after E0, busy never high, shiftReg unchanged.
- A new burst may be accepted in the cycle done is high.
- Reset mid-burst: all outputs to reset values immediately, no done.

## Structure
- Package shift_pkg: mode constants MODE_LOGIC, MODE_ROT, MODE_ARITH; FSM state encoding IDLE/SHIFT.
- One sub-module shift_step: combinational, Width-parametrised, inputs value/dir/mode/shiftIn, outputs next value and out bit; shared by single-shift and burst paths.
- Top holds FSM, counter, latched dir/mode, registers.

## Test plan
(Width=8)
- Reset asserted during a 5-step burst -> shiftReg 0x00, shiftOut 0, busy 0, done 0 the same cycle; no later done.
- Load 0xB4, single shift right logical, shiftIn=1 -> shiftReg 0xDA, shiftOut 0, done stays 0.
- Load 0x96, burst N=3 rotate left -> busy 3 cycles, then shiftReg 0xB4, shiftOut 0, done one-cycle pulse.
- Load 0x90, burst N=4 arithmetic right -> shiftReg 0xF9, shiftOut 0; dir toggled mid-burst has no effect.
- burstLen=0 -> done next cycle, busy never high, value unchanged; load 0xFF, burstLen=15, logical left, shiftIn=0 -> clamps to 8, busy 8 cycles, shiftReg 0x00, shiftOut 1.
- Load 0x3C asserted on second busy cycle of a 6-step burst -> shiftReg 0x3C next cycle, busy 0, no done pulse; subsequent shift request accepted.
